// File: rtl/tt_sweep_checker_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// Holds the sweep FSM state encoding, default MISR constants and the expected-bit indexing helper.
package tt_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_LOG,
    S_DONE
  } state_e;

  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;

  // LSB position of vector vec's expected response inside the packed truth table.
  function automatic int unsigned exp_lsb(input int unsigned vec, input int unsigned n_out);
    return vec * n_out;
  endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Per-vector log record channel (valid/ready) of the sweep checker.
// The checker drives it through the master modport; a log consumer uses the slave modport.
interface tt_sweep_checker_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
);
  logic             log_valid;
  logic             log_ready;
  logic [N_IN-1:0]  log_vec;
  logic [N_OUT-1:0] log_resp;
  logic             log_fail;

  modport master (
    output log_valid, log_vec, log_resp, log_fail,
    input  log_ready
  );

  modport slave (
    input  log_valid, log_vec, log_resp, log_fail,
    output log_ready
  );
endinterface

// File: rtl/tt_sweep_checker_misr.sv
// Multiple-input signature register: shift left, fold in POLY when the MSB falls out, XOR in data.
// load has priority over en and restarts the signature from SEED.
module tt_misr
  import tt_sweep_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_SIG_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SIG_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments; reset is synchronous and active-high here.
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives vectors 0..2^N_IN-1, samples the DUT after SETTLE cycles,
// checks against EXP, counts mismatches, signs every response and streams one log record per vector.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int                         N_IN     = 3,
  parameter int                         N_OUT    = 1,
  parameter int                         SETTLE   = 1,
  parameter logic [N_OUT*(1<<N_IN)-1:0] EXP      = 8'b1110_1000,
  parameter bit                         LOG_EN   = 1'b1,
  parameter int                         SIG_W    = 16,
  parameter logic [SIG_W-1:0]           SIG_POLY = DEF_SIG_POLY,
  parameter logic [SIG_W-1:0]           SIG_SEED = DEF_SIG_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [N_IN-1:0]    stim_o,
  input  logic [N_OUT-1:0]   resp_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_IN:0]      err_count,
  output logic               first_fail_valid,
  output logic [N_IN-1:0]    first_fail_vec,
  output logic [SIG_W-1:0]   signature,
  tt_sweep_checker_if.master log_if
);

  localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffvec_q, ffvec_d;
  logic              log_valid_q, log_valid_d;
  logic [N_IN-1:0]   log_vec_q, log_vec_d;
  logic [N_OUT-1:0]  log_resp_q, log_resp_d;
  logic              log_fail_q, log_fail_d;

  logic              advance;
  logic              misr_load;
  logic [N_OUT-1:0]  exp_resp;
  logic              mismatch;

  assign exp_resp = N_OUT'(EXP >> exp_lsb(32'(vec_q), N_OUT));
  assign mismatch = (resp_i != exp_resp);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    ffv_d      = ffv_q;
    ffvec_d    = ffvec_q;
    log_vec_d  = log_vec_q;
    log_resp_d = log_resp_q;
    log_fail_d = log_fail_q;
    advance    = 1'b0;
    misr_load  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_SETTLE;
          vec_d     = '0;
          cnt_d     = '0;
          err_d     = '0;
          ffv_d     = 1'b0;
          ffvec_d   = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          misr_load = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        log_vec_d  = vec_q;
        log_resp_d = resp_i;
        log_fail_d = mismatch;
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        if (LOG_EN) state_d = S_LOG;
        else        advance = 1'b1;
      end
      S_LOG: begin
        if (log_if.log_ready) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // pass looks at err_d so the LOG_EN=0 path, which advances out of SAMPLE, sees the last mismatch.
    if (advance) begin
      if (vec_q == LAST_VEC) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end else begin
        state_d = S_SETTLE;
        vec_d   = vec_q + 1'b1;
      end
    end

    // Outputs are decoded from the next state so they are registered yet line up with the state.
    busy_d      = (state_d == S_SETTLE) || (state_d == S_SAMPLE) || (state_d == S_LOG);
    stim_d      = busy_d ? vec_d : '0;
    log_valid_d = LOG_EN && (state_d == S_LOG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ffv_q       <= 1'b0;
      ffvec_q     <= '0;
      log_valid_q <= 1'b0;
      log_vec_q   <= '0;
      log_resp_q  <= '0;
      log_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ffv_q       <= ffv_d;
      ffvec_q     <= ffvec_d;
      log_valid_q <= log_valid_d;
      log_vec_q   <= log_vec_d;
      log_resp_q  <= log_resp_d;
      log_fail_q  <= log_fail_d;
    end
  end

  tt_misr #(
    .SIG_W (SIG_W),
    .POLY  (SIG_POLY),
    .SEED  (SIG_SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (misr_load),
    .en   (state_q == S_SAMPLE),
    .data (SIG_W'(resp_i)),
    .sig  (signature)
  );

  assign stim_o           = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

  assign log_if.log_valid = log_valid_q;
  assign log_if.log_vec   = log_vec_q;
  assign log_if.log_resp  = log_resp_q;
  assign log_if.log_fail  = log_fail_q;

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Synthesisable, parametrised exhaustive truth-table sweeper and checker for an N-input combinational DUT.
- Drives every input vector 0..2^N_IN-1 in ascending order and waits a programmable settle time per vector.
- Compares each DUT response against an expected truth table, counts mismatches and folds every response into a MISR signature.
- Streams per-vector records over a valid/ready log port. Sits beside the DUT in synth-level self-test wrappers.

Parameters:
- N_IN, 3, DUT input width (1..12).
- N_OUT, 1, DUT output width (1..SIG_W).
- SETTLE, 1, cycles each vector is held before sampling (>=1).
- EXP, 8'b1110_1000, expected truth table, N_OUT*2^N_IN bits; vector v expects EXP[v*N_OUT +: N_OUT].
- LOG_EN, 1, 1 = per-vector log handshake enabled; 0 = LOG state skipped, log_valid tied 0.
- SIG_W, 16, MISR width.
- SIG_POLY, 16'h1021, MISR feedback polynomial.
- SIG_SEED, 16'hFFFF, MISR value loaded on start.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a sweep when not busy.
- stim_o  out  N_IN  vector driven to the DUT.
- resp_i  in  N_OUT  DUT response.
- busy  out  1  sweep in progress.
- done  out  1  high from sweep end until next start or rst.
- pass  out  1  err_count==0; meaningful only while done=1.
- err_count  out  N_IN+1  mismatch count.
- first_fail_valid  out  1  at least one mismatch seen.
- first_fail_vec  out  N_IN  lowest failing vector.
- signature  out  SIG_W  MISR state.
- log_valid  out  1  log record valid.
- log_ready  in  1  log consumer ready.
- log_vec  out  N_IN  vector of the record.
- log_resp  out  N_OUT  sampled response.
- log_fail  out  1  record mismatched.

Behaviour:
- Reset values: all outputs 0. State IDLE, vector counter 0, settle counter 0.
- States are IDLE, SETTLE, SAMPLE, LOG, DONE.
- IDLE/DONE:
  - stim_o=0 and busy=0.
  - start=1 clears err_count, first_fail_*, done and pass; loads signature=SIG_SEED; sets vec=0; enters SETTLE.
- SETTLE:
  - stim_o=vec and busy=1.
  - Held exactly SETTLE cycles, then goes to SAMPLE.
- SAMPLE (1 cycle):
  - Register resp_i into log_resp; set log_vec=vec; log_fail = (resp_i != expected).
  - On mismatch, err_count+1. If first_fail_valid=0, set first_fail_vec=vec and first_fail_valid=1.
  - signature <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zero-extended resp_i.
  - Next state is LOG if LOG_EN, else advance.
- LOG:
  - log_valid=1; stim_o holds vec; log_* fields stable.
  - Stays while log_ready=0. On log_valid & log_ready, advance.
- Advance:
  - If vec==2^N_IN-1: DONE, with done=1 and pass=(err_count==0), both effective the cycle after the final advance.
  - Otherwise: vec+1, then SETTLE.
- Throughput: with log_ready held 1, each vector takes SETTLE+2 cycles (SETTLE+1 when LOG_EN=0).
  - Full sweep: 2^N_IN*(SETTLE+2) cycles from the start-sampled edge to done rising.
- start while busy: ignored, no effect.
- rst at any time: all outputs return to 0 on the next edge; the sweep is aborted with no partial done.
- err_count width N_IN+1 cannot overflow (max 2^N_IN). The vector counter never wraps; the terminal vector exits to DONE.
- resp_i is sampled only in SAMPLE; it is ignored in all other states.

Decomposition:
- Package tt_sweep_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, LOG, DONE);
  - default SIG_POLY and SIG_SEED constants;
  - a function computing expected-bit indexing.
- One sub-module, tt_misr: SIG_W-wide MISR with load, enable and data inputs, parametrised by polynomial.

Test Plan:
- Majority DUT, defaults, log_ready=1 → records vec 0..7 in order; err_count=0, pass=1, done rises 24 cycles after start; signature equals model.
- Stuck-at-0 DUT output, defaults → log_fail on vectors 3,5,6,7; err_count=4, first_fail_vec=3, first_fail_valid=1, pass=0.
- log_ready=0 for 5 cycles during vector 2 → log_valid held, stim_o=2 and err_count frozen throughout; sweep then completes with identical results.
- rst asserted while stim_o=5 → next cycle all outputs 0. A subsequent start sweeps from 0 and gives full correct results.
- start pulsed at vector 4 mid-sweep → no restart, sweep ends normally with 8 records. start in DONE → new sweep; done drops the cycle after start.
- N_IN=4, N_OUT=2, SETTLE=3, LOG_EN=0, EXP built for a 2-bit adder {a+b}, correct DUT → err_count=0, done after 16*4=64 cycles, log_valid never asserted.
